// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with byte register file, address mask and local access port
module i2c_target_regfile #(
    parameter logic [6:0] TGT_ADDR   = 7'h50,
    parameter logic [6:0] ADDR_MASK  = 7'h7F,
    parameter int         DEPTH      = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        PW         = $clog2(DEPTH)
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic          loc_we,
    input  logic [PW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic [7:0]    loc_rdata,
    output logic          i2c_wr_stb,
    output logic [PW-1:0] i2c_wr_addr,
    output logic [7:0]    i2c_wr_data,
    output logic          busy,
    output logic          stop_det
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PTR, S_WRITE, S_READ, S_WAIT} state_t;

    // Count value at which a persistently differing sample flips the filter output
    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [3:0]    scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic          scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          stop_q, stop_d;
    logic          wr_stb_q, wr_stb_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [DEPTH];

    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]    rx_byte;
    logic          addr_hit;
    logic [2:0]    tx_idx;
    logic          bus_we;

    // Bus conditions are judged on filtered levels; START/STOP need SCL high on both samples
    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_c  = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop_c   = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

    // Byte as it stands once the current bit is shifted in (valid on the 8th rising edge)
    assign rx_byte  = {rx_q, sda_f_q};
    assign addr_hit = ((rx_byte[7:1] & ADDR_MASK) == (TGT_ADDR & ADDR_MASK)) && (rx_byte[7:1] != 7'd0);
    assign tx_idx   = 3'(4'd7 - bit_cnt_q);

    // Synchroniser, glitch filters and the transfer state machine next-state logic
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_p_d    = scl_f_q;
        sda_p_d    = sda_f_q;

        scl_f_d   = scl_f_q;
        scl_cnt_d = 4'd0;
        if (scl_sync_q[1] != scl_f_q) begin
            if (scl_cnt_q == CNT_LAST) scl_f_d = ~scl_f_q;
            else                       scl_cnt_d = scl_cnt_q + 4'd1;
        end
        sda_f_d   = sda_f_q;
        sda_cnt_d = 4'd0;
        if (sda_sync_q[1] != sda_f_q) begin
            if (sda_cnt_q == CNT_LAST) sda_f_d = ~sda_f_q;
            else                       sda_cnt_d = sda_cnt_q + 4'd1;
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        stop_d    = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bus_we    = 1'b0;

        if (stop_c) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b1;
        end else if (start_c) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WRITE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == S_ADDR) begin
                                if (addr_hit) begin
                                    busy_d = 1'b1;
                                    rw_d   = rx_byte[0];
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d = rx_byte[PW-1:0];
                            end else begin
                                bus_we    = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_q + 1'b1;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (state_q == S_ADDR && rw_q) begin
                            state_d  = S_READ;
                            tx_d     = mem_q[ptr_q];
                            sda_oe_d = ~mem_q[ptr_q][7];
                        end else if (state_q == S_ADDR) begin
                            state_d = S_PTR;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_rise && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd9;
                        if (sda_f_q) state_d = S_WAIT;
                        else         ptr_d   = ptr_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = 4'd0;
                        tx_d      = mem_q[ptr_q];
                        sda_oe_d  = ~mem_q[ptr_q][7];
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        sda_oe_d = ~tx_q[tx_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset returns the lines to idle-high and releases SDA
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_cnt_q  <= 4'd0;
            sda_cnt_q  <= 4'd0;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            rx_q       <= 7'd0;
            tx_q       <= 8'd0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            stop_q     <= stop_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file; the bus write is placed last so it wins a same-address collision
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            if (loc_we) mem_q[loc_addr] <= loc_wdata;
            if (bus_we) mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign stop_det    = stop_q;
    assign i2c_wr_stb  = wr_stb_q;
    assign i2c_wr_addr = wr_addr_q;
    assign i2c_wr_data = wr_data_q;
    assign loc_rdata   = mem_q[loc_addr];

endmodule
